// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: datapath width, ALU select
// encodings and the divider state encoding.
package ex_div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    SEL_ADD    = 5'b00000,
    SEL_SUB    = 5'b00001,
    SEL_SLL    = 5'b00010,
    SEL_SLT    = 5'b00011,
    SEL_SLTU   = 5'b00100,
    SEL_XOR    = 5'b00101,
    SEL_SRL    = 5'b00110,
    SEL_SRA    = 5'b00111,
    SEL_OR     = 5'b01000,
    SEL_AND    = 5'b01001,
    SEL_MUL    = 5'b01010,
    SEL_MULH   = 5'b01011,
    SEL_DIV    = 5'b01100,
    SEL_DIVU   = 5'b01101,
    SEL_REM    = 5'b01110,
    SEL_REMU   = 5'b01111,
    SEL_MULHSU = 5'b10000,
    SEL_MULHU  = 5'b10001
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALC    = 2'd1,
    ST_SIGNFIX = 2'd2,
    ST_DONE    = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step
  import ex_div_pkg::*;
(
  input  logic [XLEN:0]   i_rem,
  input  logic            i_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN:0]   o_rem,
  output logic            o_qbit
);

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;

  // The partial remainder stays below the divisor, so the top shifted bit is
  // always zero and w_diff's MSB is a true sign bit.
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {2'b00, i_divisor};
  assign o_qbit  = ~w_diff[XLEN+1];
  assign o_rem   = o_qbit ? w_diff[XLEN:0] : w_shift[XLEN:0];

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls the
// pipeline while running and pulses o_valid with a registered result.
module ex_div_unit
  import ex_div_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [4:0]      i_select,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_result,
  output logic            o_valid,
  output logic            o_busy,
  output logic            o_stall
);

  div_state_e      r_state;
  logic [4:0]      r_op;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN:0]   r_rem;
  logic [4:0]      r_count;
  logic            r_qneg;
  logic            r_rneg;
  logic [XLEN-1:0] r_result;
  logic            r_valid;

  logic            w_isSigned;
  logic            w_isRem;
  logic            w_opOk;
  logic            w_divZero;
  logic            w_overflow;
  logic [XLEN-1:0] w_absA;
  logic [XLEN-1:0] w_absB;
  logic [XLEN:0]   w_nextRem;
  logic            w_qbit;
  logic [XLEN-1:0] w_quotFix;
  logic [XLEN-1:0] w_remFix;
  logic            w_opIsRem;

  assign w_isSigned = (i_select == SEL_DIV) || (i_select == SEL_REM);
  assign w_isRem    = (i_select == SEL_REM) || (i_select == SEL_REMU);
  assign w_opOk     = (i_select == SEL_DIV) || (i_select == SEL_DIVU) ||
                      (i_select == SEL_REM) || (i_select == SEL_REMU);
  assign w_divZero  = (i_data2 == '0);
  assign w_overflow = w_isSigned && (i_data1 == 32'h8000_0000) &&
                      (i_data2 == 32'hFFFF_FFFF);

  // Negating 0x80000000 yields 0x80000000, which reads correctly as 2^31 unsigned.
  assign w_absA = (w_isSigned && i_data1[XLEN-1]) ? -i_data1 : i_data1;
  assign w_absB = (w_isSigned && i_data2[XLEN-1]) ? -i_data2 : i_data2;

  assign w_quotFix = r_qneg ? -r_dividend : r_dividend;
  assign w_remFix  = r_rneg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_opIsRem = (r_op == SEL_REM) || (r_op == SEL_REMU);

  div_step u_step (
    .i_rem     (r_rem),
    .i_msb     (r_dividend[XLEN-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_nextRem),
    .o_qbit    (w_qbit)
  );

  // The dividend register doubles as the quotient: each step shifts one
  // dividend bit out of the top and one quotient bit into the bottom.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_result   <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (i_start && w_opOk) begin
            r_op       <= i_select;
            r_dividend <= w_absA;
            r_divisor  <= w_absB;
            r_qneg     <= w_isSigned && (i_data1[XLEN-1] ^ i_data2[XLEN-1]);
            r_rneg     <= w_isSigned && i_data1[XLEN-1];
            r_rem      <= '0;
            r_count    <= '0;
            if (w_divZero) begin
              r_result <= w_isRem ? i_data1 : 32'hFFFF_FFFF;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end else if (w_overflow) begin
              r_result <= w_isRem ? 32'h0000_0000 : 32'h8000_0000;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem      <= w_nextRem;
          r_dividend <= {r_dividend[XLEN-2:0], w_qbit};
          r_count    <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= ST_SIGNFIX;
        end
        ST_SIGNFIX: begin
          r_result <= w_opIsRem ? w_remFix : w_quotFix;
          r_valid  <= 1'b1;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_result = r_result;
  assign o_valid  = r_valid;
  assign o_busy   = (r_state == ST_CALC) || (r_state == ST_SIGNFIX);
  assign o_stall  = (i_start && w_opOk && (r_state == ST_IDLE) && !i_flush) || o_busy;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed testbench for ex_div_unit: hand-computed quotients/remainders,
// latency, stall coverage, flush abort and asynchronous reset.
module tb_ex_div_unit;
  import ex_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  select;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic [31:0] result;
  logic        valid;
  logic        busy;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  ex_div_unit dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_select (select),
    .i_data1  (data1),
    .i_data2  (data2),
    .i_flush  (flush),
    .o_result (result),
    .o_valid  (valid),
    .o_busy   (busy),
    .o_stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launches one operation and follows it to its VALID pulse; expLat counts
  // clock edges after the START edge until VALID is seen.
  task automatic applyStimulus(input string tag, input logic [4:0] sel,
                               input logic [31:0] a, input logic [31:0] b,
                               input int expLat, input logic [31:0] expRes);
    int   lat;
    logic stallGap;
    @(negedge clk);
    start  = 1'b1;
    select = sel;
    data1  = a;
    data2  = b;
    #1;
    checkOutput({tag, " stall_at_start"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    stallGap = 1'b0;
    while (!valid && lat < 60) begin
      if (!stall) stallGap = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " stall_gap"}, {31'd0, stallGap}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, " valid_pulse_end"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int   sawValid;
    rst    = 1'b1;
    start  = 1'b0;
    select = SEL_ADD;
    data1  = '0;
    data2  = '0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset valid", {31'd0, valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("div_100_7",   SEL_DIV,  32'd100, 32'd7, 33, 32'd14);
    applyStimulus("rem_100_7",   SEL_REM,  32'd100, 32'd7, 33, 32'd2);
    applyStimulus("div_m7_2",    SEL_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    applyStimulus("rem_m7_2",    SEL_REM,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    applyStimulus("divu_big_2",  SEL_DIVU, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC);
    applyStimulus("remu_big_2",  SEL_REMU, 32'hFFFF_FFF9, 32'd2, 33, 32'd1);
    applyStimulus("div_100_m7",  SEL_DIV,  32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2);
    applyStimulus("rem_100_m7",  SEL_REM,  32'd100, 32'hFFFF_FFF9, 33, 32'd2);
    applyStimulus("divu_5_0",    SEL_DIVU, 32'd5, 32'd0, 0, 32'hFFFF_FFFF);
    applyStimulus("rem_5_0",     SEL_REM,  32'd5, 32'd0, 0, 32'd5);
    applyStimulus("div_ovf",     SEL_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    applyStimulus("rem_ovf",     SEL_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);

    // Flush mid-calculation, then restart immediately.
    @(negedge clk);
    start  = 1'b1;
    select = SEL_DIV;
    data1  = 32'd1000;
    data2  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush busy", {31'd0, busy}, 32'd0);
    checkOutput("flush valid", {31'd0, valid}, 32'd0);
    checkOutput("flush stall", {31'd0, stall}, 32'd0);
    checkOutput("flush result_held", result, 32'd0);
    applyStimulus("divu_9_3", SEL_DIVU, 32'd9, 32'd3, 33, 32'd3);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start  = 1'b1;
    select = SEL_DIV;
    data1  = 32'd1000;
    data2  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async_reset valid", {31'd0, valid}, 32'd0);
    checkOutput("async_reset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // A non-divide select code must not start the unit.
    @(negedge clk);
    start  = 1'b1;
    select = SEL_ADD;
    data1  = 32'd100;
    data2  = 32'd7;
    #1;
    checkOutput("add_start stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("add_start busy", {31'd0, busy}, 32'd0);
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) sawValid = 1;
    end
    checkOutput("add_start no_activity", sawValid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Sequential radix-2 restoring divider in the EX stage of the RV32IM pipeline.
- It sits beside the combinational ALU and takes the same operand buses and 5-bit ALU select code.
- It executes DIV/DIVU/REM/REMU over multiple cycles and stalls the pipeline through the hazard unit while it runs.
- Its RESULT is muxed into the EX/MEM result path in place of the ALU RESULT when VALID is high.

Parameters:
- XLEN, 32, operand/result width.
- SEL_DIV, 5'b01100, ALU select code for signed quotient.
- SEL_DIVU, 5'b01101, ALU select code for unsigned quotient.
- SEL_REM, 5'b01110, ALU select code for signed remainder.
- SEL_REMU, 5'b01111, ALU select code for unsigned remainder.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- SELECT  in  5  ALU select code; must be one of the SEL_* codes to start.
- DATA1  in  32  dividend.
- DATA2  in  32  divisor.
- FLUSH  in  1  branch/exception flush; aborts any operation.
- RESULT  out  32  quotient or remainder; registered.
- VALID  out  1  RESULT valid; one-cycle pulse.
- BUSY  out  1  high while in CALC or SIGNFIX.
- STALL  out  1  combinational: (START & op_ok & IDLE & ~FLUSH) | BUSY.

Behaviour:
- Reset (asynchronous): state=IDLE; RESULT=0, VALID=0, BUSY=0; internal registers cleared. Reset mid-operation abandons the operation with no VALID.
- States: IDLE, CALC, SIGNFIX, DONE.
- op_ok means SELECT matches one of the four SEL_* codes. START with any other SELECT is ignored.
- IDLE, on START & op_ok & ~FLUSH:
  - Latch the op code.
  - Latch the operand magnitudes: absolute value for DIV/REM, raw value for DIVU/REMU.
  - Latch the quotient sign (sign1^sign2) and the remainder sign (sign1).
  - Clear the 33-bit partial remainder and set count=0.
- IDLE special cases go straight to DONE and load RESULT on the same edge:
  - DATA2==0: quotient = 32'hFFFFFFFF; remainder = DATA1 (unmodified).
  - Signed op with DATA1==32'h80000000 and DATA2==32'hFFFFFFFF: quotient = 32'h80000000; remainder = 0.
- CALC, one restoring step per edge:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor from rem[32:0].
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - count increments. After the step with count==31, go to SIGNFIX (exactly 32 CALC edges).
- SIGNFIX:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set (signed ops only).
  - Select quotient or remainder by op and register it into RESULT. Go to DONE.
- DONE: VALID=1 for exactly this cycle, BUSY=0. Next edge returns to IDLE. RESULT holds its value until the next load.
- Latency, with START sampled at edge n:
  - Normal op: VALID high in the cycle after edge n+33.
  - Special case: VALID high in the cycle after edge n.
- START arriving in CALC/SIGNFIX/DONE is ignored. The pipeline must hold operands via STALL. No queueing.
- FLUSH, any state: next edge goes to IDLE with VALID=0 and RESULT unchanged. FLUSH in DONE suppresses nothing, because VALID is already in its only cycle. START and FLUSH together in IDLE: FLUSH wins, no start.
- Arithmetic widths: 33-bit partial remainder prevents trial-subtract overflow. Absolute value of 32'h80000000 is treated as unsigned 2^31.

Decomposition:
- Shared package/header holds:
  - the ALU select encodings (all 18 opcodes, including the SEL_* values above);
  - the state encoding (2-bit IDLE=0, CALC=1, SIGNFIX=2, DONE=3);
  - XLEN.
- One natural sub-module: div_step, the combinational single restoring step. It maps (rem, dividend msb, divisor) to (next rem, quotient bit).

Test Plan:
- DIV 100/7 -> RESULT=14; then REM 100/7 -> RESULT=2. Check VALID asserts exactly 33 cycles after START, and STALL is high from the START cycle through SIGNFIX.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 32'hFFFFFFF9/2 -> 32'h7FFFFFFC; REMU 32'hFFFFFFF9/2 -> 1.
- DIVU 5/0 -> 32'hFFFFFFFF; REM 5/0 -> 5. Both must have VALID one cycle after START and no CALC cycles.
- DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000; REM of the same operands -> 0. Both must take the one-cycle path.
- START DIV 1000/3, FLUSH at cycle 10 -> no VALID, BUSY low the next cycle. An immediate new START of DIVU 9/3 -> RESULT=3 after 33 cycles.
- Assert RESET at cycle 15 of an operation -> BUSY/VALID/RESULT are 0 immediately (asynchronously). START with SELECT=ADD (5'b00000) -> ignored, STALL stays 0.
